// File: rtl/irq_dispatch.sv
// irq_dispatch: captures the priority encoder's winning group/channel, presents
// it to the CPU as a frozen vector with a req/ack handshake, and on acknowledge
// emits a one-cycle one-hot clear pulse for the originating source, followed by
// a settle interval before the encoder is sampled again.
//
// Handshake: irq_req is high exactly while in PEND. irq_ack is level-sampled on
// each rising edge and only acted on in PEND. An ack seen at edge k makes clr
// high for the single cycle after k. Ack held high produces one clr per capture.
//
// Optional feature macro: IRQ_DISPATCH_TIMEOUT_EN. When it is defined, a PEND
// that lasts TIMEOUT_CYC cycles without ack sets the sticky err flag, which
// err_clr clears. When it is undefined, err is 0 and PEND waits indefinitely.
//
// state_dbg exposes the FSM state: 0=IDLE, 1=PEND, 2=CLEAR, 3=SETTLE.
module irq_dispatch #(
  parameter int NGRP        = 3,
  parameter int NCH         = 9,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NGRP-1:0]      grp_valid,
  input  logic [3:0]           chan_code,
  input  logic                 irq_ack,
  input  logic                 err_clr,
  output logic                 irq_req,
  output logic [5:0]           irq_vec,
  output logic [NGRP*NCH-1:0]  clr,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           state_dbg
);

  localparam int NSRC    = NGRP * NCH;
  localparam int IW      = $clog2(NSRC);
  localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [3:0]    NCH_L       = 4'(NCH);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    CLEAR  = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    grp_sel;
  logic [IW-1:0] src_idx;

  // Lowest set grp_valid bit wins (group 0 is highest priority).
  always_comb begin
    grp_sel = '0;
    for (int g = NGRP - 1; g >= 0; g--) begin
      if (grp_valid[g]) grp_sel = 2'(g);
    end
  end

  // Next state and captured vector; encoder inputs only matter in IDLE.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: begin
        if ((|grp_valid) && (chan_code < NCH_L)) begin
          state_d = PEND;
          vec_d   = {grp_sel, chan_code};
        end
      end
      PEND: begin
        if (irq_ack) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counter restarts at 0 on every state change and never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == SETTLE) && (cnt_q != SETTLE_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
`ifdef IRQ_DISPATCH_TIMEOUT_EN
    else if ((state_q == PEND) && (cnt_q != CW'(TIMEOUT_CYC))) begin
      cnt_d = cnt_q + 1'b1;
    end
`endif
  end

  // State, vector and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef IRQ_DISPATCH_TIMEOUT_EN
  logic err_q, err_d;

  // Sticky timeout flag; a new timeout in the same cycle as err_clr wins.
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if ((state_q == PEND) && !irq_ack && (cnt_q == CW'(TIMEOUT_CYC - 1))) err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err            = 1'b0;
`endif

  // Decode the frozen vector back to the source bit; only driven in CLEAR.
  always_comb begin
    src_idx = IW'(vec_q[5:4]) * IW'(NCH) + IW'(vec_q[3:0]);
    clr     = '0;
    if (state_q == CLEAR) clr = NSRC'(1) << src_idx;
  end

  assign irq_req   = (state_q == PEND);
  assign busy      = (state_q != IDLE);
  assign irq_vec   = vec_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_irq_dispatch.sv
// Directed testbench for irq_dispatch (SETTLE_CYC=2, TIMEOUT_CYC=4).
// Inputs are driven 1ns after a rising edge; outputs are checked at that same
// point, so each check sees the state that the preceding edge produced.
module tb_irq_dispatch;

  logic        clk;
  logic        rst;
  logic [2:0]  grp_valid;
  logic [3:0]  chan_code;
  logic        irq_ack;
  logic        err_clr;
  logic        irq_req;
  logic [5:0]  irq_vec;
  logic [26:0] clr;
  logic        busy;
  logic        err;
  logic [1:0]  state_dbg;

  int n_cmp;
  int n_bad;

  irq_dispatch #(
    .NGRP(3), .NCH(9), .SETTLE_CYC(2), .TIMEOUT_CYC(4)
  ) dut (
    .clk(clk), .rst(rst), .grp_valid(grp_valid), .chan_code(chan_code),
    .irq_ack(irq_ack), .err_clr(err_clr), .irq_req(irq_req), .irq_vec(irq_vec),
    .clr(clr), .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; grp_valid = 3'b111; chan_code = 4'd2; irq_ack = 1'b0; err_clr = 1'b0;
    drain(2);
    n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b exp=0", irq_req); end
    n_cmp++; if (irq_vec !== 6'd0) begin n_bad++; $display("FAIL reset_vec got=%h exp=00", irq_vec); end
    n_cmp++; if (clr !== 27'd0) begin n_bad++; $display("FAIL reset_clr got=%h exp=0", clr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
    rst = 1'b0; grp_valid = 3'b000; chan_code = 4'd0;
    tick();
  endtask

  task automatic test_capture();
    grp_valid = 3'b110; chan_code = 4'd5;
    tick();
    n_cmp++; if (irq_req !== 1'b1) begin n_bad++; $display("FAIL cap_req got=%b exp=1", irq_req); end
    n_cmp++; if (irq_vec !== 6'b01_0101) begin n_bad++; $display("FAIL cap_vec got=%b exp=010101", irq_vec); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL cap_busy got=%b exp=1", busy); end
    grp_valid = 3'b001; chan_code = 4'd2;
    tick();
    n_cmp++; if (irq_vec !== 6'b01_0101) begin n_bad++; $display("FAIL cap_frozen got=%b exp=010101", irq_vec); end
    n_cmp++; if (clr !== 27'd0) begin n_bad++; $display("FAIL cap_noclr got=%h exp=0", clr); end
    grp_valid = 3'b000; irq_ack = 1'b1;
    tick();
    n_cmp++; if (clr !== 27'h0004000) begin n_bad++; $display("FAIL cap_clr got=%h exp=0004000", clr); end
    n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL cap_req_clear got=%b exp=0", irq_req); end
    irq_ack = 1'b0;
    drain(3);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cap_idle got=%b exp=0", busy); end
    n_cmp++; if (irq_vec !== 6'b01_0101) begin n_bad++; $display("FAIL cap_vec_hold got=%b exp=010101", irq_vec); end
  endtask

  task automatic test_clear_timing();
    grp_valid = 3'b111; chan_code = 4'd3;
    tick();
    n_cmp++; if (irq_vec !== 6'b00_0011) begin n_bad++; $display("FAIL ct_vec got=%b exp=000011", irq_vec); end
    irq_ack = 1'b1;
    tick();  // ack sampled at edge k
    n_cmp++; if (clr !== 27'h0000008) begin n_bad++; $display("FAIL ct_clr got=%h exp=0000008", clr); end
    irq_ack = 1'b0; grp_valid = 3'b010; chan_code = 4'd7;
    tick();
    n_cmp++; if (clr !== 27'd0) begin n_bad++; $display("FAIL ct_clr_once got=%h exp=0", clr); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ct_settle1 got=%b exp=1", busy); end
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ct_settle2 got=%b exp=1", busy); end
    n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL ct_settle_req got=%b exp=0", irq_req); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ct_idle got=%b exp=0", busy); end
    n_cmp++; if (irq_vec !== 6'b00_0011) begin n_bad++; $display("FAIL ct_vec_hold got=%b exp=000011", irq_vec); end
    tick();  // earliest new capture
    n_cmp++; if (irq_vec !== 6'b01_0111) begin n_bad++; $display("FAIL ct_recap got=%b exp=010111", irq_vec); end
    n_cmp++; if (irq_req !== 1'b1) begin n_bad++; $display("FAIL ct_recap_req got=%b exp=1", irq_req); end
    grp_valid = 3'b000; irq_ack = 1'b1;
    tick();
    n_cmp++; if (clr !== 27'h0010000) begin n_bad++; $display("FAIL ct_clr2 got=%h exp=0010000", clr); end
    irq_ack = 1'b0;
    drain(3);
  endtask

  task automatic test_invalid_chan();
    grp_valid = 3'b001; chan_code = 4'd12;
    drain(2);
    n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL inv_req got=%b exp=0", irq_req); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL inv_busy got=%b exp=0", busy); end
    chan_code = 4'd8;
    tick();
    n_cmp++; if (irq_vec !== 6'b00_1000) begin n_bad++; $display("FAIL inv_vec got=%b exp=001000", irq_vec); end
    n_cmp++; if (irq_req !== 1'b1) begin n_bad++; $display("FAIL inv_req2 got=%b exp=1", irq_req); end
    grp_valid = 3'b000; irq_ack = 1'b1;
    tick();
    n_cmp++; if (clr !== 27'h0000100) begin n_bad++; $display("FAIL inv_clr got=%h exp=0000100", clr); end
    irq_ack = 1'b0;
    drain(3);
  endtask

  task automatic test_back_to_back();
    int pulses;
    int pos0;
    int pos1;
    pulses = 0; pos0 = -1; pos1 = -1;
    grp_valid = 3'b001; chan_code = 4'd8; irq_ack = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (clr !== 27'd0) begin
        n_cmp++; if (clr !== 27'h0000100) begin n_bad++; $display("FAIL b2b_onehot got=%h exp=0000100", clr); end
        if (pulses == 0) pos0 = i; else pos1 = i;
        pulses++;
      end
    end
    n_cmp++; if (pulses !== 2) begin n_bad++; $display("FAIL b2b_count got=%0d exp=2", pulses); end
    n_cmp++; if (pos0 !== 2) begin n_bad++; $display("FAIL b2b_first got=%0d exp=2", pos0); end
    n_cmp++; if (pos1 !== 7) begin n_bad++; $display("FAIL b2b_second got=%0d exp=7", pos1); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    grp_valid = 3'b000; irq_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_clear();
    int extra;
    extra = 0;
    grp_valid = 3'b100; chan_code = 4'd8;
    tick();
    n_cmp++; if (irq_vec !== 6'b10_1000) begin n_bad++; $display("FAIL ric_vec got=%b exp=101000", irq_vec); end
    grp_valid = 3'b000; irq_ack = 1'b1;
    tick();
    n_cmp++; if (clr !== 27'h4000000) begin n_bad++; $display("FAIL ric_clr got=%h exp=4000000", clr); end
    rst = 1'b1; irq_ack = 1'b0;
    tick();
    n_cmp++; if (clr !== 27'd0) begin n_bad++; $display("FAIL ric_clr_rst got=%h exp=0", clr); end
    n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL ric_req got=%b exp=0", irq_req); end
    n_cmp++; if (irq_vec !== 6'd0) begin n_bad++; $display("FAIL ric_vec_rst got=%h exp=00", irq_vec); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ric_busy got=%b exp=0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ric_err got=%b exp=0", err); end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (clr[26] === 1'b1) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL ric_repulse got=%0d exp=0", extra); end
  endtask

  task automatic test_rst_ack();
    grp_valid = 3'b010; chan_code = 4'd1;
    tick();
    n_cmp++; if (irq_vec !== 6'b01_0001) begin n_bad++; $display("FAIL ra_vec got=%b exp=010001", irq_vec); end
    grp_valid = 3'b000; rst = 1'b1; irq_ack = 1'b1;
    tick();
    n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL ra_req got=%b exp=0", irq_req); end
    n_cmp++; if (irq_vec !== 6'd0) begin n_bad++; $display("FAIL ra_vec_rst got=%h exp=00", irq_vec); end
    n_cmp++; if (clr !== 27'd0) begin n_bad++; $display("FAIL ra_clr got=%h exp=0", clr); end
    rst = 1'b0; irq_ack = 1'b0;
    tick();
    n_cmp++; if (clr !== 27'd0) begin n_bad++; $display("FAIL ra_clr_next got=%h exp=0", clr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ra_busy got=%b exp=0", busy); end
  endtask

  task automatic test_timeout();
    grp_valid = 3'b001; chan_code = 4'd4;
    tick();
    n_cmp++; if (irq_vec !== 6'b00_0100) begin n_bad++; $display("FAIL to_vec got=%b exp=000100", irq_vec); end
    grp_valid = 3'b000;
    drain(3);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL to_err_early got=%b exp=0", err); end
`ifdef IRQ_DISPATCH_TIMEOUT_EN
    tick();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_err_set got=%b exp=1", err); end
    n_cmp++; if (irq_req !== 1'b1) begin n_bad++; $display("FAIL to_still_pend got=%b exp=1", irq_req); end
    tick();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_err_sticky got=%b exp=1", err); end
    err_clr = 1'b1;
    tick();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL to_err_clr got=%b exp=0", err); end
    err_clr = 1'b0;
    tick();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL to_err_stay got=%b exp=0", err); end
`else
    drain(3);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL to_err_off got=%b exp=0", err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
`endif
    n_cmp++; if (irq_req !== 1'b1) begin n_bad++; $display("FAIL to_req got=%b exp=1", irq_req); end
    irq_ack = 1'b1;
    tick();
    n_cmp++; if (clr !== 27'h0000010) begin n_bad++; $display("FAIL to_clr got=%h exp=0000010", clr); end
    irq_ack = 1'b0;
    drain(3);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL to_idle got=%b exp=0", busy); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_capture();
    test_clear_timing();
    test_invalid_chan();
    test_back_to_back();
    test_reset_in_clear();
    test_rst_ack();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
